// File: rtl/image_loader.sv
// Deserialises the binarised image and the first-layer 3x3 filter bank from a
// byte stream while the top-level FSM sits in its load state.
module image_loader #(
    parameter int IMG_DIM   = 28,
    parameter int N_FILTERS = 8,
    parameter int BUS_W     = 8
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [2:0]                          state,
    input  logic [BUS_W-1:0]                    data_in,
    input  logic                                data_valid,
    output logic                                ready,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0]     pixels,
    output logic [N_FILTERS-1:0][2:0][2:0]      weights,
    output logic                                load_done
);

    localparam logic [2:0] S_LOAD     = 3'b001;
    localparam int PIX_BITS    = IMG_DIM * IMG_DIM;
    localparam int WGT_BITS    = N_FILTERS * 9;
    localparam int PIX_BYTES   = PIX_BITS / BUS_W;
    localparam int WGT_BYTES   = WGT_BITS / BUS_W;
    localparam int TOTAL_BYTES = PIX_BYTES + WGT_BYTES;
    localparam int CNT_W       = $clog2(TOTAL_BYTES);
    localparam int PIX_AW      = $clog2(PIX_BITS);
    localparam int WGT_AW      = $clog2(WGT_BITS);

    logic [CNT_W-1:0]    r_byte_cnt;
    logic                r_load_done;
    logic [PIX_BITS-1:0] r_pix;
    logic [WGT_BITS-1:0] r_wgt;

    logic                w_accept;
    logic                w_in_pix;
    logic                w_last;
    logic [CNT_W-1:0]    w_wgt_idx;
    logic [PIX_AW-1:0]   w_pix_base;
    logic [WGT_AW-1:0]   w_wgt_base;

    assign ready     = (state == S_LOAD) && !r_load_done;
    assign w_accept  = ready && data_valid;
    assign w_in_pix  = r_byte_cnt < CNT_W'(PIX_BYTES);
    assign w_last    = r_byte_cnt == CNT_W'(TOTAL_BYTES - 1);
    assign w_wgt_idx = r_byte_cnt - CNT_W'(PIX_BYTES);

    // The packed output layouts put pixels[r][c] at flat bit r*IMG_DIM+c and
    // weights[f][i][j] at f*9+i*3+j, i.e. exactly the linear stream index, so
    // a byte landing across a row or filter boundary needs no special decode.
    assign w_pix_base = PIX_AW'(r_byte_cnt) * PIX_AW'(BUS_W);
    assign w_wgt_base = WGT_AW'(w_wgt_idx) * WGT_AW'(BUS_W);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, matching the hardware.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the image and filter arrays are real registers whose
            // cleared state is observable, so they are reset like any other
            // state; a mid-load reset must leave no stale bits behind.
            r_byte_cnt  <= '0;
            r_load_done <= 1'b0;
            r_pix       <= '0;
            r_wgt       <= '0;
        end else if (w_accept) begin
            if (w_in_pix) begin
                r_pix[w_pix_base +: BUS_W] <= data_in;
            end else begin
                r_wgt[w_wgt_base +: BUS_W] <= data_in;
            end
            if (w_last) begin
                r_load_done <= 1'b1;
            end else begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    assign pixels    = r_pix;
    assign weights   = r_wgt;
    assign load_done = r_load_done;

endmodule
